// File: rtl/data_mem_responder_pkg.sv
// Shared memory-access types and lane helpers for the data-memory responder:
// mask encoding, byte enables, store lane replication, load extension, access legality.
package data_mem_responder_pkg;

    typedef enum logic [2:0] {
        mt_b  = 3'd0,
        mt_h  = 3'd1,
        mt_w  = 3'd2,
        mt_bu = 3'd3,
        mt_hu = 3'd4,
        mt_x  = 3'd5
    } ME_MaskType;

    function automatic logic [3:0] get_byte_enable(input ME_MaskType mask, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (mask)
            mt_b, mt_bu: be = 4'b0001 << lane;
            mt_h, mt_hu: be = lane[1] ? 4'b1100 : 4'b0011;
            mt_w:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-aligned store data copied onto every lane; byte enables pick the live ones.
    function automatic logic [31:0] get_store_data(input ME_MaskType mask, input logic [31:0] data);
        logic [31:0] wd;
        wd = data;
        case (mask)
            mt_b, mt_bu: wd = {4{data[7:0]}};
            mt_h, mt_hu: wd = {2{data[15:0]}};
            default:     wd = data;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] get_load_data(input ME_MaskType mask, input logic [1:0] lane,
                                                  input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] rd;
        b  = word[{lane, 3'b000} +: 8];
        h  = lane[1] ? word[31:16] : word[15:0];
        rd = 32'h0;
        case (mask)
            mt_b:    rd = {{24{b[7]}}, b};
            mt_bu:   rd = {24'h0, b};
            mt_h:    rd = {{16{h[15]}}, h};
            mt_hu:   rd = {16'h0, h};
            mt_w:    rd = word;
            default: rd = 32'h0;
        endcase
        return rd;
    endfunction

    // Mask/alignment legality only; the array range check lives with the array size.
    function automatic logic is_mem_access_error(input ME_MaskType mask, input logic write,
                                                 input logic [1:0] addr_lo);
        logic err;
        err = 1'b1;
        case (mask)
            mt_b:    err = 1'b0;
            mt_bu:   err = write;
            mt_h:    err = addr_lo[0];
            mt_hu:   err = write | addr_lo[0];
            mt_w:    err = (addr_lo != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/data_mem_sram.sv
// WORDS x 32 storage, synchronous per-byte write, combinational read.
// Zero read latency; no flow control, the caller owns sequencing.
module data_mem_sram #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_be[i]) begin
                r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// One-at-a-time load/store target: response LATENCY edges after acceptance, store commits on that edge.
// req_ready only in IDLE; the response is held stable until rsp_ready, no queueing.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic        req_write,
    input  ME_MaskType  req_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [29:0] LP_WORDS  = 30'(MEM_WORDS);
    localparam logic [3:0]  LP_CNT_LD = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_write;
    ME_MaskType  r_mask;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_fire;
    logic        w_err;
    logic [3:0]  w_be;
    logic [31:0] w_rdata;

    assign w_fire = (r_state == S_BUSY) && (r_cnt == 4'd0);
    assign w_err  = is_mem_access_error(r_mask, r_write, r_addr[1:0]) || (r_addr[31:2] >= LP_WORDS);
    // Only the completing edge of a legal store may touch the array.
    assign w_be   = (w_fire && r_write && !w_err) ? get_byte_enable(r_mask, r_addr[1:0]) : 4'b0000;

    data_mem_sram #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk     (clk),
        .i_addr  (r_addr[AW+1:2]),
        .i_be    (w_be),
        .i_wdata (get_store_data(r_mask, r_data)),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= 32'h0;
            r_data     <= 32'h0;
            r_write    <= 1'b0;
            r_mask     <= mt_b;
            r_rsp_data <= 32'h0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_data  <= req_data;
                        r_write <= req_write;
                        r_mask  <= req_mask;
                        r_cnt   <= LP_CNT_LD;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_err  <= w_err;
                        r_rsp_data <= (w_err || r_write) ? 32'h0
                                                         : get_load_data(r_mask, r_addr[1:0], w_rdata);
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: lane access, extension, errors, backpressure, mid-op reset.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int MEM_WORDS = 1024;
    localparam int LATENCY   = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_write;
    ME_MaskType  req_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_write (req_write),
        .req_mask  (req_mask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One full transaction; hold>0 keeps rsp_ready low that many cycles, intrude offers a
    // competing store during that time which must never be accepted.
    task automatic txn(input string tag, input logic wr, input ME_MaskType m, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_data, input logic exp_err,
                       input int hold, input logic intrude);
        int n;
        @(negedge clk);
        check({tag, "_rdy_idle"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_mask  = m;
        req_addr  = a;
        req_data  = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (rsp_valid) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(LATENCY));
        @(negedge clk);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        if (intrude) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_mask  = mt_w;
            req_addr  = 32'h300;
            req_data  = 32'hBAD0BAD0;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_vld"}, {31'b0, rsp_valid}, 32'd1);
            check({tag, "_hold_data"}, rsp_data, exp_data);
            check({tag, "_hold_rdy"}, {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_vld_drop"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_rdy_back"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_data  = 32'h0;
        req_write = 1'b0;
        req_mask  = mt_b;
        rsp_ready = 1'b0;
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        txn("st_w",     1'b1, mt_w,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 0, 1'b0);
        txn("ld_w",     1'b0, mt_w,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 0, 1'b0);
        txn("st_b",     1'b1, mt_b,  32'h101, 32'h00000080, 32'h0,        1'b0, 0, 1'b0);
        txn("ld_b",     1'b0, mt_b,  32'h101, 32'h0,        32'hFFFFFF80, 1'b0, 0, 1'b0);
        txn("ld_bu",    1'b0, mt_bu, 32'h101, 32'h0,        32'h00000080, 1'b0, 0, 1'b0);
        txn("ld_w2",    1'b0, mt_w,  32'h100, 32'h0,        32'hDEAD80EF, 1'b0, 0, 1'b0);
        txn("st_h",     1'b1, mt_h,  32'h102, 32'h00008001, 32'h0,        1'b0, 0, 1'b0);
        txn("ld_h",     1'b0, mt_h,  32'h102, 32'h0,        32'hFFFF8001, 1'b0, 0, 1'b0);
        txn("ld_hu",    1'b0, mt_hu, 32'h102, 32'h0,        32'h00008001, 1'b0, 0, 1'b0);
        txn("ld_w3",    1'b0, mt_w,  32'h100, 32'h0,        32'h800180EF, 1'b0, 0, 1'b0);

        txn("e_ld_w_mis", 1'b0, mt_w,  32'h102, 32'h0,        32'h0, 1'b1, 0, 1'b0);
        txn("e_ld_h_mis", 1'b0, mt_h,  32'h103, 32'h0,        32'h0, 1'b1, 0, 1'b0);
        txn("e_st_bu",    1'b1, mt_bu, 32'h100, 32'h000000AA, 32'h0, 1'b1, 0, 1'b0);
        txn("e_ld_oob",   1'b0, mt_w,  32'(MEM_WORDS*4), 32'h0, 32'h0, 1'b1, 0, 1'b0);
        txn("e_st_oob",   1'b1, mt_w,  32'(MEM_WORDS*4), 32'h55555555, 32'h0, 1'b1, 0, 1'b0);
        txn("e_ld_x",     1'b0, mt_x,  32'h100, 32'h0,        32'h0, 1'b1, 0, 1'b0);
        txn("ld_w_keep",  1'b0, mt_w,  32'h100, 32'h0,        32'h800180EF, 1'b0, 0, 1'b0);

        txn("st_top",  1'b1, mt_w, 32'(MEM_WORDS*4-4), 32'hA5A5A5A5, 32'h0, 1'b0, 0, 1'b0);
        txn("ld_top",  1'b0, mt_w, 32'(MEM_WORDS*4-4), 32'h0, 32'hA5A5A5A5, 1'b0, 0, 1'b0);
        txn("ld_top_b3", 1'b0, mt_bu, 32'(MEM_WORDS*4-1), 32'h0, 32'h000000A5, 1'b0, 0, 1'b0);

        txn("st_300",   1'b1, mt_w, 32'h300, 32'h11111111, 32'h0,        1'b0, 0, 1'b0);
        txn("bp_ld",    1'b0, mt_w, 32'h100, 32'h0,        32'h800180EF, 1'b0, 5, 1'b1);
        txn("ld_300",   1'b0, mt_w, 32'h300, 32'h0,        32'h11111111, 1'b0, 0, 1'b0);

        txn("st_200_0", 1'b1, mt_w, 32'h200, 32'h0,        32'h0,        1'b0, 0, 1'b0);
        txn("ld_pre",   1'b0, mt_w, 32'h100, 32'h0,        32'h800180EF, 1'b0, 0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_mask  = mt_w;
        req_addr  = 32'h200;
        req_data  = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_rdy", {31'b0, req_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("mid_rst_rsp_data", rsp_data, 32'h0);
        check("mid_rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        txn("ld_200",  1'b0, mt_w, 32'h200, 32'h0, 32'h0,        1'b0, 0, 1'b0);
        txn("ld_keep", 1'b0, mt_w, 32'h100, 32'h0, 32'h800180EF, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
